// File: rtl/debounce_pkg.sv
// Shared types and constants for the button debounce scheduler.
`timescale 1ns/1ps
package debounce_pkg;

    typedef enum logic {
        SCAN   = 1'b0,
        TIMING = 1'b1
    } fsm_state_t;

    localparam int DEFAULT_STABLE_CYCLES = 10000;

    // Index width for N buttons; never below 1 so a vector can always be declared.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_scheduler_rr_picker.sv
// Rotating-priority find-first: returns the first set request at or after ptr, wrapping.
`timescale 1ns/1ps
module rr_picker
    import debounce_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N;
            if (req[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// N-button debouncer sharing one stability timer, granted round-robin to pending buttons.
`timescale 1ns/1ps
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter  int N_BUTTONS     = 4,
    parameter  int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter  int CNT_W         = 14,
    localparam int IDX_W         = idx_w(N_BUTTONS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] button,
    output logic [N_BUTTONS-1:0] state,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic                 busy,
    output logic [IDX_W-1:0]     active_idx
);

    logic [N_BUTTONS-1:0] sync_meta, sync_q, pending, flip_vec;
    logic [IDX_W-1:0]     ptr, pick_idx, next_ptr;
    logic [CNT_W-1:0]     timer;
    logic                 found, bounced, timer_done;
    logic                 start, finish, abort;
    fsm_state_t           cur_st, nxt_st;

    assign pending    = sync_q ^ state;
    assign bounced    = (sync_q[active_idx] == state[active_idx]);
    assign timer_done = (timer == CNT_W'(STABLE_CYCLES - 1));
    assign next_ptr   = (active_idx == IDX_W'(N_BUTTONS - 1)) ? '0 : active_idx + 1'b1;
    assign busy       = (cur_st == TIMING);

    rr_picker #(.N(N_BUTTONS), .IDX_W(IDX_W)) u_picker (
        .req   (pending),
        .ptr   (ptr),
        .found (found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_st <= SCAN;
        else        cur_st <= nxt_st;
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            SCAN:   if (found) nxt_st = TIMING;
            TIMING: if (bounced || timer_done) nxt_st = SCAN;
        endcase
    end

    // A bounce back to the accepted level takes priority over timer expiry.
    always_comb begin
        start    = 1'b0;
        finish   = 1'b0;
        abort    = 1'b0;
        flip_vec = '0;
        case (cur_st)
            SCAN:   start = found;
            TIMING: begin
                if (bounced)         abort  = 1'b1;
                else if (timer_done) finish = 1'b1;
            end
        endcase
        if (finish) flip_vec = N_BUTTONS'(1) << active_idx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta     <= '0;
            sync_q        <= '0;
            state         <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            ptr           <= '0;
            timer         <= '0;
            active_idx    <= '0;
        end else begin
            sync_meta     <= button;
            sync_q        <= sync_meta;
            state         <= state ^ flip_vec;
            press_pulse   <= flip_vec & ~state;
            release_pulse <= flip_vec & state;
            if (start) begin
                active_idx <= pick_idx;
                timer      <= '0;
            end
            if (abort || finish) ptr <= next_ptr;
            else if (cur_st == TIMING) timer <= timer + 1'b1;
        end
    end

endmodule
